seg_disp_arbiter: RTL and testbench
===================================

Name: seg_disp_arbiter

Overview:
Shares one six-digit 74HC595 dynamic seven-segment driver (seg_595_dynamic) between three content sources, such as a counter, a sensor readout and a status/clock value. It grants the display with round-robin arbitration and holds each owner for a minimum visible time. It inserts a blank gap on every owner change to avoid ghosting. Its output drives the data/point/sign/seg_en inputs of seg_595_dynamic directly, replacing the single data_gen connection in the display top level.

Parameters:
HOLD_MAX, 26'd49_999_999, minimum OWN time minus 1, in sys_clk cycles (1 s at 50 MHz).
GAP_MAX, 26'd4_999, blank gap length minus 1, in cycles (100 us).

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst  in  1  synchronous, active-high reset.
req  in  3  request per source; bit i = source i.
data_in  in  60  packed source data; [20i+19:20i] = source i value (0..999_999).
point_in  in  18  packed decimal-point masks; [6i+5:6i].
sign_in  in  3  negative-sign flag per source.
gnt  out  3  one-hot grant; 0 when no owner.
owner_id  out  2  index of the current owner; 0 when idle.
data  out  20  value to the display driver.
point  out  6  decimal-point mask to the driver.
sign  out  1  sign to the driver.
seg_en  out  1  display enable to the driver.

Behaviour:
- Reset (sys_rst=1 at an edge): state=IDLE, gnt=0, owner_id=0, data=0, point=0, sign=0, seg_en=0, cnt=0, rr_ptr=2. Reset mid-operation aborts OWN or GAP at that edge.
- Counter cnt is 26 bits. It clears on every state entry, increments each cycle and saturates at the state's MAX value.
- Round-robin pick: search order is rr_ptr+1, rr_ptr+2, rr_ptr (mod 3). The first asserted req wins. After reset this gives order 0,1,2.
- IDLE:
  - gnt=0.
  - If any req is set, pick -> next cycle OWN, with owner=pick, rr_ptr=pick, gnt=onehot(pick).
- OWN:
  - gnt=onehot(owner).
  - Registered outputs each cycle: data/point/sign <= owner's slice of the inputs; seg_en<=1. Outputs follow input changes with 1 cycle latency.
  - Owner req drops (takes priority over everything else): if another req is pending -> GAP; otherwise -> IDLE.
  - cnt==HOLD_MAX and another source's req is set -> GAP.
  - cnt==HOLD_MAX with no other request -> stay in OWN, cnt saturated. The next competing req switches on the following cycle.
- GAP:
  - gnt=0. Outputs registered to data=0, point=0, sign=0, seg_en=0.
  - Lasts GAP_MAX+1 cycles.
  - At cnt==GAP_MAX: re-pick from current req. A hit -> OWN with the new owner; no hit -> IDLE.
  - The old owner is eligible only after the others (it sits last in round-robin order).
- Leaving OWN: gnt drops at the transition edge; data/point/sign/seg_en clear one cycle later. They stay 0 throughout IDLE.
- Grant latency: req seen in IDLE at cycle N -> gnt at N+1 -> seg_en=1 and valid data at N+2.
- OWN lasts at least HOLD_MAX+1 cycles unless the owner drops req.
- HOLD_MAX=0 and GAP_MAX=0 are legal (1-cycle OWN, 1-cycle GAP).
- Values on req/data_in of non-owners are ignored. No range check on data_in (the driver handles values above 999_999).

Decomposition:
- Package seg_arb_pkg:
  - constants NUM_REQ=3, DATA_W=20, POINT_W=6;
  - state enum {IDLE, OWN, GAP};
  - function rr_next(req, ptr) returning a hit flag and an index.
- One sub-module, seg_rr_pick: combinational 3-way round-robin picker, taking req and rr_ptr and returning hit and idx. Instantiated once; the FSM, counter and output registers stay in seg_disp_arbiter.

Test Plan (HOLD_MAX=9, GAP_MAX=2):
1. Reset 3 cycles, all req=0 -> every output 0 and gnt=0 throughout; then req=3'b100 at cycle 10 -> gnt=3'b100 at 11, owner_id=2, seg_en=1 at 12.
2. Only req1 with data_in[39:20]=123456, point 6'b000100 -> data=123456 and point=000100 held for 100+ cycles; gnt never drops.
3. req=3'b111 continuously -> gnt sequence: 001 for 10 cycles, 0 for 3, 010 for 10, 0 for 3, 100 for 10, 0 for 3, then 001. seg_en=0 exactly during the gaps, delayed by 1 cycle.
4. Owner 0 drops req at cnt=4 with req2 set -> GAP of 3 cycles, then gnt=3'b100. Repeat with no other req -> IDLE next cycle, seg_en=0 one cycle later.
5. During OWN, owner data_in changes 654321->000042 and sign 0->1 -> data and sign update exactly 1 cycle later with no gnt change.
6. sys_rst pulsed mid-GAP and mid-OWN -> all outputs 0 at the next edge; after release with req=3'b110, source 1 is granted first (rr_ptr reset to 2).

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types and helpers for the six-digit display arbiter.
// Holds the source count and widths, the state set, and the round-robin search.
package seg_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 20;
  localparam int POINT_W = 6;
  localparam int CNT_W   = 26;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } rr_pick_t;

  // Search ptr+1, ptr+2, ptr (mod 3), so the last owner is tried last.
  function automatic rr_pick_t rr_next(input logic [NUM_REQ-1:0] req,
                                       input logic [1:0] ptr);
    rr_pick_t   r;
    logic [1:0] i;
    r = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = 2'((int'(ptr) + k) % NUM_REQ);
      if (!r.hit && req[i]) begin
        r.hit = 1'b1;
        r.idx = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational 3-way round-robin picker.
// Returns the first asserted request after rr_ptr, wrapping back to rr_ptr itself.
module seg_rr_pick
  import seg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               hit,
  output logic [1:0]         idx
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_next(req, rr_ptr);
    hit  = pick.hit;
    idx  = pick.idx;
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of a shared seg_595_dynamic driver with a minimum hold time
// and a blank gap between owners, so one source's digits never ghost into the next.
module seg_disp_arbiter
  import seg_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] HOLD_MAX = 26'd49_999_999,
  parameter logic [CNT_W-1:0] GAP_MAX  = 26'd4_999
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  input  logic [NUM_REQ*POINT_W-1:0]  point_in,
  input  logic [NUM_REQ-1:0]          sign_in,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [1:0]                  owner_id,
  output logic [DATA_W-1:0]           data,
  output logic [POINT_W-1:0]          point,
  output logic                        sign,
  output logic                        seg_en
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_OWN  = OWN;
  localparam logic [1:0] S_GAP  = GAP;

  logic [1:0]       state, state_nx;
  logic [1:0]       owner, owner_nx;
  logic [1:0]       rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_max;

  logic                              hit;
  logic [1:0]                        idx;
  logic [NUM_REQ-1:0]                own_mask;
  logic                              owner_req, other_req;
  logic [NUM_REQ-1:0][DATA_W-1:0]    data_v;
  logic [NUM_REQ-1:0][POINT_W-1:0]   point_v;

  assign data_v  = data_in;
  assign point_v = point_in;

  seg_rr_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .hit    (hit),
    .idx    (idx)
  );

  assign own_mask  = NUM_REQ'(3'b001 << owner);
  assign owner_req = |(req & own_mask);
  assign other_req = |(req & ~own_mask);

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    case (state)
      S_IDLE: begin
        if (hit) begin
          state_nx  = S_OWN;
          owner_nx  = idx;
          rr_ptr_nx = idx;
        end
      end
      S_OWN: begin
        // A dropped owner request wins over the hold timer.
        if (!owner_req)
          state_nx = other_req ? S_GAP : S_IDLE;
        else if (cnt == HOLD_MAX && other_req)
          state_nx = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_MAX) begin
          if (hit) begin
            state_nx  = S_OWN;
            owner_nx  = idx;
            rr_ptr_nx = idx;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign cnt_max = (state == S_OWN) ? HOLD_MAX : GAP_MAX;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= S_IDLE;
      owner  <= 2'd0;
      rr_ptr <= 2'd2;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_ptr_nx;
      if (state_nx != state || state == S_IDLE)
        cnt <= '0;
      else if (cnt != cnt_max)
        cnt <= cnt + 1'b1;
    end
  end

  // Display outputs lag the state by one cycle, so they blank one cycle after gnt drops.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state != S_OWN) begin
      data   <= '0;
      point  <= '0;
      sign   <= 1'b0;
      seg_en <= 1'b0;
    end else begin
      data   <= data_v[owner];
      point  <= point_v[owner];
      sign   <= sign_in[owner];
      seg_en <= 1'b1;
    end
  end

  assign gnt      = (state == S_OWN) ? own_mask : '0;
  assign owner_id = (state == S_OWN) ? owner : 2'd0;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter with short hold/gap times.
// Directed scenarios plus randomized requests, compared every cycle against a behavioural model.
module tb_seg_disp_arbiter;

  localparam logic [25:0] HM = 26'd9;
  localparam logic [25:0] GM = 26'd2;
  localparam int M_IDLE = 0, M_OWN = 1, M_GAP = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req;
  logic [59:0] data_in;
  logic [17:0] point_in;
  logic [2:0]  sign_in;
  logic [2:0]  gnt;
  logic [1:0]  owner_id;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;

  seg_disp_arbiter #(.HOLD_MAX(HM), .GAP_MAX(GM)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .data_in  (data_in),
    .point_in (point_in),
    .sign_in  (sign_in),
    .gnt      (gnt),
    .owner_id (owner_id),
    .data     (data),
    .point    (point),
    .sign     (sign),
    .seg_en   (seg_en)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode, time spent in mode, owner and last grant.
  int          m_mode, m_time, m_owner, m_last;
  logic [19:0] e_data;
  logic [5:0]  e_point;
  logic        e_sign, e_en;

  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic model_edge();
    int  p;
    bit  others;
    if (sys_rst) begin
      m_mode = M_IDLE; m_time = 0; m_owner = 0; m_last = 2;
      e_data = 0; e_point = 0; e_sign = 0; e_en = 0;
      return;
    end
    if (m_mode == M_OWN) begin
      e_data  = data_in[20*m_owner +: 20];
      e_point = point_in[6*m_owner +: 6];
      e_sign  = sign_in[m_owner];
      e_en    = 1'b1;
    end else begin
      e_data = 0; e_point = 0; e_sign = 0; e_en = 0;
    end
    case (m_mode)
      M_IDLE: begin
        p = pick(req, m_last);
        if (p >= 0) begin m_mode = M_OWN; m_owner = p; m_last = p; m_time = 0; end
      end
      M_OWN: begin
        others = 1'b0;
        for (int i = 0; i < 3; i++) if (i != m_owner && req[i]) others = 1'b1;
        if (!req[m_owner]) begin
          m_mode = others ? M_GAP : M_IDLE; m_time = 0;
        end else if (m_time >= int'(HM) && others) begin
          m_mode = M_GAP; m_time = 0;
        end else m_time++;
      end
      default: begin
        if (m_time == int'(GM)) begin
          p = pick(req, m_last);
          if (p >= 0) begin m_mode = M_OWN; m_owner = p; m_last = p; end
          else m_mode = M_IDLE;
          m_time = 0;
        end else m_time++;
      end
    endcase
  endtask

  task automatic step();
    logic [2:0] e_gnt;
    @(posedge sys_clk);
    model_edge();
    #1;
    e_gnt = (m_mode == M_OWN) ? 3'(1 << m_owner) : 3'b000;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    if (m_mode != M_GAP)
      chk("owner_id", 32'(owner_id), (m_mode == M_OWN) ? 32'(m_owner) : 32'd0);
    chk("data", 32'(data), 32'(e_data));
    chk("point", 32'(point), 32'(e_point));
    chk("sign", 32'(sign), 32'(e_sign));
    chk("seg_en", 32'(seg_en), 32'(e_en));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    sys_rst = 1'b1; req = 3'b000; data_in = '0; point_in = '0; sign_in = '0;
    m_mode = M_IDLE; m_time = 0; m_owner = 0; m_last = 2;
    e_data = 0; e_point = 0; e_sign = 0; e_en = 0;

    // Reset then idle, then source 2 requests.
    steps(3);
    sys_rst = 1'b0;
    steps(6);
    data_in[59:40] = 20'd777; req = 3'b100;
    step();
    chk("p1_gnt", 32'(gnt), 32'b100);
    chk("p1_owner", 32'(owner_id), 32'd2);
    step();
    chk("p1_en", 32'(seg_en), 32'd1);

    // Source 1 alone holds the display indefinitely.
    data_in[39:20] = 20'd123456; point_in[11:6] = 6'b000100; req = 3'b010;
    steps(120);
    chk("p2_data", 32'(data), 32'd123456);
    chk("p2_point", 32'(point), 32'b000100);
    chk("p2_gnt", 32'(gnt), 32'b010);

    // All requesting: rotate with gaps.
    req = 3'b111;
    steps(80);

    // Owner drop with and without a competitor.
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    req = 3'b001; step();
    chk("p4_gnt0", 32'(gnt), 32'b001);
    steps(4);
    req = 3'b100; step();
    chk("p4_gap", 32'(gnt), 32'b000);
    steps(3);
    chk("p4_gnt2", 32'(gnt), 32'b100);
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    req = 3'b001; step(); steps(4);
    req = 3'b000; step();
    chk("p4_idle_gnt", 32'(gnt), 32'b000);
    chk("p4_en_lag", 32'(seg_en), 32'd1);
    step();
    chk("p4_en_off", 32'(seg_en), 32'd0);

    // Live data follows with one cycle latency.
    data_in[19:0] = 20'd654321; sign_in[0] = 1'b0; req = 3'b001;
    steps(4);
    chk("p5_data0", 32'(data), 32'd654321);
    data_in[19:0] = 20'd42; sign_in[0] = 1'b1;
    step();
    chk("p5_data1", 32'(data), 32'd42);
    chk("p5_sign", 32'(sign), 32'd1);
    chk("p5_gnt", 32'(gnt), 32'b001);

    // Reset mid-GAP and mid-OWN, then check rr pointer restart.
    req = 3'b111;
    steps(12);
    sys_rst = 1'b1; step();
    chk("p6_rst_gnt", 32'(gnt), 32'd0);
    chk("p6_rst_en", 32'(seg_en), 32'd0);
    sys_rst = 1'b0; steps(5);
    sys_rst = 1'b1; step();
    chk("p6_rst2_data", 32'(data), 32'd0);
    sys_rst = 1'b0; req = 3'b110; step();
    chk("p6_first", 32'(gnt), 32'b010);
    steps(30);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req[$urandom_range(2)] = ~req[$urandom_range(2)];
      if ($urandom_range(15) == 0) req = 3'($urandom);
      data_in  = {28'($urandom), 32'($urandom)};
      point_in = 18'($urandom);
      sign_in  = 3'($urandom);
      sys_rst  = ($urandom_range(499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
